// File: rtl/efuse_shadow_load_pkg.sv
// Shared constants and FSM state type for the efuse shadow loader.
package efuse_pkg;
    localparam int EFUSE_BITS = 256;
    localparam int TRIM_BITS  = 248;
    localparam int CHK_BYTE   = 31;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        CHECK,
        APPLY
    } efuse_shadow_state_e;
endpackage

// File: rtl/efuse_shadow_load_if.sv
// Autoload stream from the efuse controller plus the published shadow outputs.
interface efuse_shadow_load_if
    import efuse_pkg::*;
#(
    parameter int NR = 64
);
    localparam int WORDS = EFUSE_BITS / NR;
    localparam int SEL_W = $clog2(WORDS);

    logic                 pmu_efuse_start;
    logic                 rg_efuse_refresh;
    logic                 efuse_autoload_vld;
    logic [SEL_W-1:0]     efuse_read_sel;
    logic [NR-1:0]        rg_efuse_rdata;
    logic                 efuse_autoload_done;
    logic [TRIM_BITS-1:0] shadow_trim;
    logic                 shadow_vld;
    logic                 shadow_chk_err;
    logic                 shadow_miss_err;
    logic                 shadow_busy;

    modport master (
        output pmu_efuse_start, rg_efuse_refresh, efuse_autoload_vld,
               efuse_read_sel, rg_efuse_rdata, efuse_autoload_done,
        input  shadow_trim, shadow_vld, shadow_chk_err, shadow_miss_err, shadow_busy
    );

    modport slave (
        input  pmu_efuse_start, rg_efuse_refresh, efuse_autoload_vld,
               efuse_read_sel, rg_efuse_rdata, efuse_autoload_done,
        output shadow_trim, shadow_vld, shadow_chk_err, shadow_miss_err, shadow_busy
    );
endinterface

// File: rtl/efuse_shadow_load_xor_chk.sv
// Sequential XOR over image bytes 0..30, one byte per cycle, compared with byte 31.
// done is high on the cycle the last byte is folded in; pass is valid the cycle after.
module efuse_xor_chk
    import efuse_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [EFUSE_BITS-1:0] img,
    output logic                  done,
    output logic                  pass
);
    localparam logic [4:0] LAST = 5'(CHK_BYTE - 1);

    logic       run;
    logic [4:0] cnt;
    logic [7:0] acc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run <= 1'b0;
            cnt <= '0;
            acc <= '0;
        end else if (start) begin
            run <= 1'b1;
            cnt <= '0;
            acc <= '0;
        end else if (run) begin
            acc <= acc ^ img[{cnt, 3'b000} +: 8];
            // Counter parks at the last byte index instead of wrapping.
            if (cnt == LAST) begin
                run <= 1'b0;
            end else begin
                cnt <= cnt + 5'd1;
            end
        end
    end

    assign done = run && (cnt == LAST);
    assign pass = (acc == img[CHK_BYTE*8 +: 8]);
endmodule

// File: rtl/efuse_shadow_load.sv
// Collects autoload words into a 256-bit image, checks its XOR byte and publishes the trim.
// Shadow outputs update 32 cycles after done on a pass, 1 cycle after done on a miss; no backpressure.
module efuse_shadow_load
    import efuse_pkg::*;
#(
    parameter int                   NR        = 64,
    parameter logic [TRIM_BITS-1:0] TRIM_DFLT = '0
)
(
    input  logic               clk,
    input  logic               rst_n,
    efuse_shadow_load_if.slave bus
);
    localparam int WORDS = EFUSE_BITS / NR;

    efuse_shadow_state_e   state;
    logic [NR-1:0]         words [WORDS];
    logic [WORDS-1:0]      word_mask;
    logic [WORDS-1:0]      mask_next;
    logic [EFUSE_BITS-1:0] img;
    logic                  start_req;
    logic                  mask_full;
    logic                  chk_start;
    logic                  chk_done;
    logic                  chk_pass;

    always_comb begin
        img = '0;
        for (int k = 0; k < WORDS; k++) begin
            img[k*NR +: NR] = words[k];
        end
    end

    // A word arriving together with done counts towards completeness.
    always_comb begin
        mask_next = word_mask;
        if (bus.efuse_autoload_vld) begin
            mask_next[bus.efuse_read_sel] = 1'b1;
        end
    end

    assign mask_full = &mask_next;
    assign start_req = bus.pmu_efuse_start | bus.rg_efuse_refresh;
    assign chk_start = (state == COLLECT) && bus.efuse_autoload_done && mask_full;

    efuse_xor_chk u_chk (
        .clk   (clk),
        .rst_n (rst_n),
        .start (chk_start),
        .img   (img),
        .done  (chk_done),
        .pass  (chk_pass)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state               <= IDLE;
            word_mask           <= '0;
            for (int k = 0; k < WORDS; k++) begin
                words[k] <= '0;
            end
            bus.shadow_trim     <= TRIM_DFLT;
            bus.shadow_vld      <= 1'b0;
            bus.shadow_chk_err  <= 1'b0;
            bus.shadow_miss_err <= 1'b0;
            bus.shadow_busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_req) begin
                        word_mask           <= '0;
                        bus.shadow_chk_err  <= 1'b0;
                        bus.shadow_miss_err <= 1'b0;
                        bus.shadow_busy     <= 1'b1;
                        state               <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (bus.efuse_autoload_vld) begin
                        words[bus.efuse_read_sel] <= bus.rg_efuse_rdata;
                    end
                    word_mask <= mask_next;
                    if (bus.efuse_autoload_done) begin
                        if (mask_full) begin
                            state <= CHECK;
                        end else begin
                            bus.shadow_miss_err <= 1'b1;
                            bus.shadow_busy     <= 1'b0;
                            state               <= IDLE;
                        end
                    end
                end
                CHECK: begin
                    if (chk_done) begin
                        state <= APPLY;
                    end
                end
                APPLY: begin
                    if (chk_pass) begin
                        bus.shadow_trim <= img[TRIM_BITS-1:0];
                        bus.shadow_vld  <= 1'b1;
                    end else begin
                        bus.shadow_chk_err <= 1'b1;
                    end
                    bus.shadow_busy <= 1'b0;
                    state           <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_efuse_shadow_load.sv
// Directed bench for efuse_shadow_load with NR=64 (four words per image).
module tb_efuse_shadow_load;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    efuse_shadow_load_if #(.NR(64)) bus ();

    efuse_shadow_load #(.NR(64), .TRIM_DFLT('0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [255:0] img;
        logic [3:0]   send;
        logic         done_with_last;
        int           exp_lat;
        logic         exp_vld_pre;
        logic         exp_vld;
        logic         exp_chk;
        logic         exp_miss;
        logic [247:0] exp_trim;
    } vec_t;

    vec_t         vecs [4];
    logic [255:0] img_a, img_a1, img_c, img_d;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic send_word(input int k, input logic [63:0] d, input logic with_done);
        bus.efuse_autoload_vld  = 1'b1;
        bus.efuse_read_sel      = 2'(k);
        bus.rg_efuse_rdata      = d;
        bus.efuse_autoload_done = with_done;
        tick();
        bus.efuse_autoload_vld  = 1'b0;
        bus.efuse_autoload_done = 1'b0;
    endtask

    task automatic pulse_done();
        bus.efuse_autoload_done = 1'b1;
        tick();
        bus.efuse_autoload_done = 1'b0;
    endtask

    task automatic pulse_start();
        bus.pmu_efuse_start = 1'b1;
        tick();
        bus.pmu_efuse_start = 1'b0;
    endtask

    // Counts cycles until busy drops; pre holds shadow_vld from the last busy sample.
    task automatic wait_idle(output int lat, output logic pre);
        lat = 0;
        pre = bus.shadow_vld;
        while (bus.shadow_busy === 1'b1 && lat < 200) begin
            pre = bus.shadow_vld;
            tick();
            lat++;
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int   lat;
        logic pre;
        pulse_start();
        check($sformatf("v%0d_busy_start", idx), 256'(bus.shadow_busy), 256'(1));
        for (int k = 0; k < 4; k++) begin
            if (v.send[k]) send_word(k, v.img[k*64 +: 64], v.done_with_last && k == 3);
        end
        if (!v.done_with_last) pulse_done();
        wait_idle(lat, pre);
        check($sformatf("v%0d_latency", idx), 256'(lat), 256'(v.exp_lat));
        check($sformatf("v%0d_vld_pre", idx), 256'(pre), 256'(v.exp_vld_pre));
        check($sformatf("v%0d_vld", idx), 256'(bus.shadow_vld), 256'(v.exp_vld));
        check($sformatf("v%0d_chk_err", idx), 256'(bus.shadow_chk_err), 256'(v.exp_chk));
        check($sformatf("v%0d_miss_err", idx), 256'(bus.shadow_miss_err), 256'(v.exp_miss));
        check($sformatf("v%0d_trim", idx), 256'(bus.shadow_trim), 256'(v.exp_trim));
    endtask

    initial begin
        int   lat;
        logic pre;

        // img_a: byte b = b+1 for b=0..30; XOR of 1..31 is 0, so checksum 0x00 passes.
        img_a = '0;
        for (int b = 0; b < 31; b++) img_a[8*b +: 8] = 8'(b + 1);
        img_a1 = img_a;
        img_a1[255:248] = 8'h01;
        // img_c: 31 bytes of 0x5A, odd count, so checksum 0x5A.
        img_c = {32{8'h5A}};
        // img_d: img_a with word 2 = 0x55.. ; remaining bytes XOR to 0x08.
        img_d = img_a;
        img_d[191:128] = 64'h5555_5555_5555_5555;
        img_d[255:248] = 8'h08;

        vecs[0] = '{img_a,  4'b1111, 1'b0, 32, 1'b0, 1'b1, 1'b0, 1'b0, img_a[247:0]};
        vecs[1] = '{img_a1, 4'b1111, 1'b0, 32, 1'b1, 1'b1, 1'b1, 1'b0, img_a[247:0]};
        vecs[2] = '{img_c,  4'b1011, 1'b0, 0,  1'b1, 1'b1, 1'b0, 1'b1, img_a[247:0]};
        vecs[3] = '{img_c,  4'b1111, 1'b1, 32, 1'b1, 1'b1, 1'b0, 1'b0, img_c[247:0]};

        rst_n                   = 1'b0;
        bus.pmu_efuse_start     = 1'b0;
        bus.rg_efuse_refresh    = 1'b0;
        bus.efuse_autoload_vld  = 1'b0;
        bus.efuse_read_sel      = '0;
        bus.rg_efuse_rdata      = '0;
        bus.efuse_autoload_done = 1'b0;
        tick();
        tick();
        check("rst_trim", 256'(bus.shadow_trim), 256'(0));
        check("rst_vld", 256'(bus.shadow_vld), 256'(0));
        check("rst_chk_err", 256'(bus.shadow_chk_err), 256'(0));
        check("rst_miss_err", 256'(bus.shadow_miss_err), 256'(0));
        check("rst_busy", 256'(bus.shadow_busy), 256'(0));
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 4; i++) run_vec(vecs[i], i);

        // Duplicate index: second write of word 2 must win.
        pulse_start();
        send_word(0, img_d[63:0], 1'b0);
        send_word(1, img_d[127:64], 1'b0);
        send_word(2, 64'hAAAA_AAAA_AAAA_AAAA, 1'b0);
        send_word(2, img_d[191:128], 1'b0);
        send_word(3, img_d[255:192], 1'b0);
        pulse_done();
        wait_idle(lat, pre);
        check("dup_latency", 256'(lat), 256'(32));
        check("dup_chk_err", 256'(bus.shadow_chk_err), 256'(0));
        check("dup_trim", 256'(bus.shadow_trim), 256'(img_d[247:0]));

        // Refresh during CHECK is ignored and the check completes on schedule.
        pulse_start();
        for (int k = 0; k < 4; k++) send_word(k, img_a[k*64 +: 64], 1'b0);
        pulse_done();
        repeat (10) tick();
        bus.rg_efuse_refresh = 1'b1;
        tick();
        bus.rg_efuse_refresh = 1'b0;
        wait_idle(lat, pre);
        check("refresh_latency", 256'(lat + 11), 256'(32));
        check("refresh_trim", 256'(bus.shadow_trim), 256'(img_a[247:0]));
        check("refresh_chk_err", 256'(bus.shadow_chk_err), 256'(0));

        // Reset during CHECK restores every output.
        pulse_start();
        for (int k = 0; k < 4; k++) send_word(k, img_c[k*64 +: 64], 1'b0);
        pulse_done();
        repeat (10) tick();
        rst_n = 1'b0;
        tick();
        check("midrst_trim", 256'(bus.shadow_trim), 256'(0));
        check("midrst_vld", 256'(bus.shadow_vld), 256'(0));
        check("midrst_busy", 256'(bus.shadow_busy), 256'(0));
        check("midrst_chk_err", 256'(bus.shadow_chk_err), 256'(0));
        check("midrst_miss_err", 256'(bus.shadow_miss_err), 256'(0));
        rst_n = 1'b1;
        tick();

        // vld and done in IDLE have no effect.
        send_word(1, 64'h1234, 1'b1);
        tick();
        check("idle_miss_err", 256'(bus.shadow_miss_err), 256'(0));
        check("idle_busy", 256'(bus.shadow_busy), 256'(0));
        check("idle_trim", 256'(bus.shadow_trim), 256'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/efuse_shadow_load.md
# efuse_shadow_load

Downstream consumer of the efuse controller's autoload stream: collects the NR-bit words read from the 256-bit efuse array, assembles them into a 256-bit image, and verifies an 8-bit XOR checksum sequentially. On a pass it publishes the 248-bit trim image as a stable shadow register for analog and trim consumers. The block sits between the efuse controller and the trim distribution logic, in the 6.5M gated clock domain.

## Interface
- NR, 64, autoload word width; 256/NR words per image (legal values 8, 16, 32, 64, 128)
- TRIM_DFLT, 248'h0, shadow_trim value after reset and while no image has ever passed
- clk  in  1  6.5M gated clock from crgu; single clock domain
- rst_n  in  1  synchronous active-low reset
- pmu_efuse_start  in  1  pulse; starts image collection
- rg_efuse_refresh  in  1  pulse; starts image collection (same effect as pmu_efuse_start)
- efuse_autoload_vld  in  1  pulse; rg_efuse_rdata holds word efuse_read_sel
- efuse_read_sel  in  $clog2(256/NR)  index of the current word
- rg_efuse_rdata  in  NR  word data
- efuse_autoload_done  in  1  pulse; autoload sequence finished
- shadow_trim  out  248  published trim image; reset value TRIM_DFLT
- shadow_vld  out  1  at least one image has passed; sticky until reset; reset 0
- shadow_chk_err  out  1  last attempt failed the checksum; reset 0
- shadow_miss_err  out  1  last attempt had missing words; reset 0
- shadow_busy  out  1  high in COLLECT, CHECK, APPLY; reset 0

## Operation
- Image layout: word k occupies img[k*NR +: NR]. Byte b is img[8b+7:8b]. Checksum byte is img[255:248]. Trim is img[247:0].
- FSM states: IDLE, COLLECT, CHECK, APPLY.
- IDLE:
  - A start (pmu_efuse_start | rg_efuse_refresh) clears word_mask, the accumulator and both error flags, then enters COLLECT.
  - vld and done are ignored in IDLE.
- COLLECT:
  - On vld, write the word at efuse_read_sel and set word_mask[sel].
  - A duplicate index overwrites the stored word; the last write wins.
  - On done with word_mask all ones, enter CHECK with byte counter 0.
  - On done with word_mask not all ones, set shadow_miss_err, keep shadow_trim, return to IDLE.
  - If vld and done arrive together, store the word first, then evaluate the mask including that word.
- CHECK:
  - Each cycle: acc ^= byte[cnt], cnt++. Runs for 31 cycles (bytes 0..30).
  - After byte 30, enter APPLY.
  - vld and done are ignored in CHECK.
- APPLY, one cycle:
  - If acc == img[255:248]: shadow_trim <= img[247:0], shadow_vld <= 1.
  - Otherwise: shadow_chk_err <= 1 and shadow_trim is unchanged.
  - Then return to IDLE.
- A start while shadow_busy is ignored; no restart.
- Reset at any point returns to IDLE and restores all reset values. A partial image is never published.
- shadow_trim only changes in APPLY on a pass, so it is glitch-free for consumers.

## Timing
- Cycle numbering: edge 0 is the edge that samples efuse_autoload_done.
- Pass case:
  - CHECK runs on edges 1..31.
  - APPLY is on edge 32; shadow_trim and shadow_vld are visible after edge 32.
  - shadow_busy falls after edge 32.
- Miss case: shadow_miss_err is visible after edge 0; shadow_busy falls after edge 0.
- Start to COLLECT: shadow_busy rises the cycle after the start pulse is sampled.
- Counter widths:
  - cnt is 5 bits and saturates at 30 before APPLY; no wrap-around.
  - word_mask is 256/NR bits.
- Inputs are assumed synchronous to clk. No internal synchronisers.

## Structure
- Shared package efuse_pkg holds: EFUSE_BITS=256, TRIM_BITS=248, CHK_BYTE=31, and the typedef efuse_shadow_state_e {IDLE, COLLECT, CHECK, APPLY}.
- One natural sub-module, efuse_xor_chk: byte counter, accumulator and compare. It exposes start, done and pass.
- The image buffer and FSM stay in the top level.

## Test plan
- NR=64: start, then words 0..3 carrying bytes 0x01..0x1F, with checksum byte 0x00. Required: after done, shadow_trim bytes = 0x01..0x1F, shadow_vld=1 exactly 32 cycles after done, no errors.
- Same image with checksum byte 0x01. Required: shadow_chk_err=1, shadow_vld and shadow_trim keep their previous values.
- Words 0, 1, 3 sent, then done. Required: shadow_miss_err=1 the cycle after done, busy drops, shadow_trim unchanged.
- Word 2 sent twice (0xAA.. then 0x55..) with a correct checksum for 0x55... Required: pass, with image word 2 = 0x55...
- rg_efuse_refresh issued mid-CHECK: ignored, and the check completes. Then rst_n=0 mid-CHECK: all outputs go to reset values, shadow_trim = TRIM_DFLT.
- vld and done in the same cycle for the last missing word (index 3). Required: the word is stored and the image passes.
